// File: rtl/mux41_rr_arb_pkg.sv
// Shared types and constants for the round-robin 4:1 burst arbiter.
// Holds the FSM encoding, channel geometry and the rotating search helper.
package mux41_rr_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int N_CH      = 4;
    localparam int SEL_W     = 2;
    localparam int DEF_DW    = 8;
    localparam int DEF_BURST = 4;

    // Returns {found, index} of the first set request at or above ptr,
    // wrapping modulo N_CH. Walking downward lets the lowest offset win.
    function automatic logic [SEL_W:0] rr_pick(
        input logic [N_CH-1:0]  req,
        input logic [SEL_W-1:0] ptr
    );
        logic [SEL_W:0]   res;
        logic [SEL_W-1:0] c;
        res = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            c = ptr + SEL_W'(i);
            if (req[c]) begin
                res = {1'b1, c};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux41_rr_arb_mux.sv
// Shared 4:1 data multiplexer for the arbiter data path.
// Pure combinational select of one channel word by index.
module mux41_case
    import mux41_rr_arb_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic [SEL_W-1:0] i_sel,
    input  logic [DW-1:0]    i_d_0,
    input  logic [DW-1:0]    i_d_1,
    input  logic [DW-1:0]    i_d_2,
    input  logic [DW-1:0]    i_d_3,
    output logic [DW-1:0]    o_y
);

    // Route the indexed channel to the output
    always_comb begin
        o_y = '0;
        case (i_sel)
            2'd0:    o_y = i_d_0;
            2'd1:    o_y = i_d_1;
            2'd2:    o_y = i_d_2;
            default: o_y = i_d_3;
        endcase
    end

endmodule

// File: rtl/mux41_rr_arb.sv
// Round-robin arbiter granting bursts of up to BURST beats from one of
// four channels into a single registered output with valid/ready flow.
module mux41_rr_arb
    import mux41_rr_arb_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int BURST = DEF_BURST
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_CH-1:0]   i_req,
    input  logic [DW-1:0]     i_d_0,
    input  logic [DW-1:0]     i_d_1,
    input  logic [DW-1:0]     i_d_2,
    input  logic [DW-1:0]     i_d_3,
    output logic [N_CH-1:0]   o_ack,
    output logic [N_CH-1:0]   o_gnt,
    output logic [SEL_W-1:0]  o_sel,
    output logic              o_valid,
    output logic [DW-1:0]     o_y,
    input  logic              i_ready
);

    // Counter value of the final beat of a full burst
    localparam logic [3:0] LAST = 4'(BURST - 1);

    state_t           state;
    logic [SEL_W-1:0] rr_ptr;
    logic [3:0]       beat;
    logic [DW-1:0]    mux_y;
    logic [SEL_W:0]   pick;
    logic             reg_free;
    logic             xfer;
    logic             burst_end;

    mux41_case #(
        .DW (DW)
    ) u_mux (
        .i_sel (o_sel),
        .i_d_0 (i_d_0),
        .i_d_1 (i_d_1),
        .i_d_2 (i_d_2),
        .i_d_3 (i_d_3),
        .o_y   (mux_y)
    );

    assign pick      = rr_pick(i_req, rr_ptr);
    assign reg_free  = !o_valid || i_ready;
    assign xfer      = (state == BUSY) && i_req[o_sel] && reg_free;
    assign burst_end = (state == BUSY)
                     && (!i_req[o_sel] || (xfer && beat == LAST));

    // Consume strobe for the granted channel, masked during reset
    always_comb begin
        o_ack = '0;
        if (xfer && !i_rst) begin
            o_ack[o_sel] = 1'b1;
        end
    end

    // Grant FSM: pick a channel in IDLE, count beats and rotate in BUSY
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            beat   <= '0;
            o_gnt  <= '0;
            o_sel  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick[SEL_W]) begin
                        state <= BUSY;
                        o_sel <= pick[SEL_W-1:0];
                        o_gnt <= 4'b0001 << pick[SEL_W-1:0];
                    end
                end
                BUSY: begin
                    if (burst_end) begin
                        state  <= IDLE;
                        o_gnt  <= '0;
                        rr_ptr <= o_sel + 2'd1;
                        beat   <= '0;
                    end else if (xfer) begin
                        beat <= beat + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output register: load on transfer, drain when accepted, hold on stall
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_y     <= '0;
        end else if (xfer) begin
            o_valid <= 1'b1;
            o_y     <= mux_y;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux41_rr_arb.sv
// Directed bench for mux41_rr_arb with a per-cycle reference model,
// plus a BURST=1 instance checked against a fixed alternating pattern.
module tb_mux41_rr_arb;

    localparam int DW = 8;
    localparam int B0 = 4;

    logic          i_clk   = 1'b0;
    logic          i_rst   = 1'b1;
    logic          i_ready = 1'b1;
    logic [3:0]    i_req   = '0;
    logic [DW-1:0] i_d_0   = '0;
    logic [DW-1:0] i_d_1   = '0;
    logic [DW-1:0] i_d_2   = '0;
    logic [DW-1:0] i_d_3   = '0;
    logic [3:0]    o_ack;
    logic [3:0]    o_gnt;
    logic [1:0]    o_sel;
    logic          o_valid;
    logic [DW-1:0] o_y;

    logic          r1_rst = 1'b1;
    logic [3:0]    a1_ack;
    logic [3:0]    a1_gnt;
    logic [1:0]    a1_sel;
    logic          a1_valid;
    logic [DW-1:0] a1_y;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    mux41_rr_arb #(.DW(DW), .BURST(B0)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_req   (i_req),
        .i_d_0   (i_d_0),
        .i_d_1   (i_d_1),
        .i_d_2   (i_d_2),
        .i_d_3   (i_d_3),
        .o_ack   (o_ack),
        .o_gnt   (o_gnt),
        .o_sel   (o_sel),
        .o_valid (o_valid),
        .o_y     (o_y),
        .i_ready (i_ready)
    );

    mux41_rr_arb #(.DW(DW), .BURST(1)) dut1 (
        .i_clk   (i_clk),
        .i_rst   (r1_rst),
        .i_req   (4'b1111),
        .i_d_0   (8'h11),
        .i_d_1   (8'h22),
        .i_d_2   (8'h33),
        .i_d_3   (8'h44),
        .o_ack   (a1_ack),
        .o_gnt   (a1_gnt),
        .o_sel   (a1_sel),
        .o_valid (a1_valid),
        .o_y     (a1_y),
        .i_ready (1'b1)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Requesters: channel n holds base+sent until acked, while remaining > 0
    int         remaining [4];
    int         sent [4];
    logic [7:0] base [4];
    logic [3:0] ack_q = '0;

    task automatic drive();
        for (int n = 0; n < 4; n++) i_req[n] = (remaining[n] > 0);
        i_d_0 = base[0] + 8'(sent[0]);
        i_d_1 = base[1] + 8'(sent[1]);
        i_d_2 = base[2] + 8'(sent[2]);
        i_d_3 = base[3] + 8'(sent[3]);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
            for (int k = 0; k < 4; k++) begin
                if (ack_q[k] && remaining[k] > 0) begin
                    remaining[k]--;
                    sent[k]++;
                end
            end
            drive();
        end
    endtask

    function automatic logic [7:0] dsel(input int c);
        case (c)
            0:       return i_d_0;
            1:       return i_d_1;
            2:       return i_d_2;
            default: return i_d_3;
        endcase
    endfunction

    // Reference model: granted channel, beats delivered, output slot
    bit         en = 0;
    bit         m_busy = 0;
    int         m_ch = 0;
    int         m_ptr = 0;
    int         m_beats = 0;
    bit         m_valid = 0;
    logic [7:0] m_y = '0;
    bit         m_xfer = 0;

    always @(negedge i_clk) begin
        m_xfer = m_busy && i_req[m_ch] && (!m_valid || i_ready) && !i_rst;
        ack_q = o_ack;
        if (en) begin
            chk("ack", o_ack, m_xfer ? (32'd1 << m_ch) : 32'd0);
            chk("gnt", o_gnt, m_busy ? (32'd1 << m_ch) : 32'd0);
            chk("sel", o_sel, m_ch);
            chk("valid", o_valid, m_valid);
            chk("y", o_y, m_y);
        end
    end

    always @(posedge i_clk) begin
        if (i_rst) begin
            m_busy = 0; m_ch = 0; m_ptr = 0;
            m_beats = 0; m_valid = 0; m_y = '0;
        end else begin
            if (m_xfer) begin
                m_y = dsel(m_ch);
                m_valid = 1;
                m_beats++;
            end else if (i_ready) begin
                m_valid = 0;
            end
            if (!m_busy) begin
                for (int k = 0; k < 4; k++) begin
                    if (!m_busy && i_req[(m_ptr + k) % 4]) begin
                        m_busy = 1;
                        m_ch = (m_ptr + k) % 4;
                    end
                end
            end else if (!i_req[m_ch] || m_beats == B0) begin
                m_busy = 0;
                m_ptr = (m_ch + 1) % 4;
                m_beats = 0;
            end
        end
    end

    // Grant / ack log for the main instance
    int         n_g = 0;
    int         glog [16];
    int         alog [16];
    logic [3:0] pg = '0;

    always @(negedge i_clk) begin
        if (o_gnt != 0 && pg == 0 && n_g < 16) begin
            glog[n_g] = o_sel;
            n_g++;
        end
        if (o_ack != 0 && n_g > 0) alog[n_g - 1]++;
        pg = o_gnt;
    end

    task automatic clear_logs();
        n_g = 0;
        for (int k = 0; k < 16; k++) begin
            glog[k] = -1;
            alog[k] = 0;
        end
    endtask

    // BURST=1 instance: grant on odd cycles, rotating 0,1,2,3
    bit en1 = 0;
    int c1 = 0;
    int n1 = 0;
    int glog1 [16];
    int alog1 [16];
    bit p1nz = 0;

    always @(negedge i_clk) begin
        if (en1) begin
            chk("b1_gnt", a1_gnt,
                (c1 % 2 == 1) ? (32'd1 << ((c1 / 2) % 4)) : 32'd0);
            chk("b1_ack", a1_ack,
                (c1 % 2 == 1) ? (32'd1 << ((c1 / 2) % 4)) : 32'd0);
            chk("b1_valid", a1_valid, (c1 >= 2 && c1 % 2 == 0) ? 1 : 0);
            if (c1 >= 2 && c1 % 2 == 0)
                chk("b1_y", a1_y, 32'h11 * (((c1 / 2) - 1) % 4 + 1));
            if (a1_gnt != 0 && !p1nz && n1 < 16) begin
                glog1[n1] = a1_sel;
                n1++;
            end
            if (a1_ack != 0 && n1 > 0) alog1[n1 - 1]++;
            p1nz = (a1_gnt != 0);
            c1++;
        end
    end

    task automatic do_reset();
        i_rst = 1'b1;
        for (int n = 0; n < 4; n++) begin
            remaining[n] = 0;
            sent[n] = 0;
            base[n] = 8'h00;
        end
        drive();
        step(2);
        i_rst = 1'b0;
        i_ready = 1'b1;
        clear_logs();
        drive();
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            glog1[k] = -1;
            alog1[k] = 0;
        end
        do_reset();
        en = 1;
        r1_rst = 1'b0;
        en1 = 1;

        // Reset state
        @(negedge i_clk);
        chk("rst_gnt", o_gnt, 0);
        chk("rst_sel", o_sel, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_y", o_y, 0);

        // All channels requesting, full bursts in rotation
        base[0] = 8'h00; base[1] = 8'h40;
        base[2] = 8'h80; base[3] = 8'hC0;
        for (int n = 0; n < 4; n++) remaining[n] = 100;
        drive();
        step(23);
        chk("rot_count", n_g, 5);
        for (int k = 0; k < 5; k++) chk("rot_order", glog[k], k % 4);
        for (int k = 0; k < 4; k++) chk("rot_beats", alog[k], 4);

        // Single request, latency of grant/ack/valid
        do_reset();
        base[2] = 8'hA5;
        remaining[2] = 1;
        drive();
        step(1);
        @(negedge i_clk);
        chk("lat_sel", o_sel, 2);
        chk("lat_ack", o_ack, 4'b0100);
        step(1);
        @(negedge i_clk);
        chk("lat_valid", o_valid, 1);
        chk("lat_y", o_y, 8'hA5);
        step(3);

        // Downstream stall after the first beat of a ch1 burst
        do_reset();
        base[1] = 8'h11;
        remaining[1] = 4;
        drive();
        step(2);
        i_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            chk("stall_ack", o_ack, 0);
            chk("stall_y", o_y, 8'h11);
            chk("stall_valid", o_valid, 1);
            step(1);
        end
        i_ready = 1'b1;
        step(8);
        chk("stall_gnt", glog[0], 1);
        chk("stall_beats", alog[0], 4);
        chk("stall_count", n_g, 1);

        // ch3 withdraws after two beats; pointer wraps to ch0
        do_reset();
        base[3] = 8'h30;
        remaining[3] = 2;
        drive();
        step(6);
        @(negedge i_clk);
        chk("drop_idle", o_gnt, 0);
        chk("drop_beats", alog[0], 2);
        base[0] = 8'h01;
        remaining[0] = 2;
        remaining[3] = 2;
        drive();
        step(9);
        chk("wrap_g0", glog[0], 3);
        chk("wrap_g1", glog[1], 0);
        chk("wrap_g2", glog[2], 3);
        chk("wrap_b1", alog[1], 2);

        // Reset pulse mid-burst on ch2
        do_reset();
        base[2] = 8'h50;
        remaining[2] = 3;
        drive();
        step(2);
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("midrst_ack", o_ack, 0);
        step(1);
        i_rst = 1'b0;
        clear_logs();
        @(negedge i_clk);
        chk("midrst_valid", o_valid, 0);
        chk("midrst_gnt", o_gnt, 0);
        step(2);
        @(negedge i_clk);
        chk("regrant_ch", glog[0], 2);
        chk("regrant_valid", o_valid, 1);
        chk("regrant_y", o_y, 8'h51);
        step(5);
        chk("regrant_beats", alog[0], 2);

        // BURST=1 instance rotation
        chk("b1_count_min", (n1 >= 8) ? 1 : 0, 1);
        for (int k = 0; k < 8; k++) begin
            chk("b1_order", glog1[k], k % 4);
            chk("b1_beats", alog1[k], 1);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
